// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH = 3;

  // Ceiling log2, for sizing pointers from a depth.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  // A programmed threshold of zero means "use the built-in default".
  function automatic int thr_sel(input int thr, input int dflt);
    return (thr == 0) ? dflt : thr;
  endfunction

endpackage

// File: rtl/param_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module param_sdp_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: storage is never cleared, only the FIFO pointers are.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: rdata holds its value between reads.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered flags, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_DEFAULT = (2**ADDR_WIDTH) - 2,
  parameter int AE_DEFAULT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   afull_thr,
  input  logic [ADDR_WIDTH:0]   aempty_thr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_C   = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  push_ok, pop_ok;
  logic                  out_clr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  int                    aft, aet;

  // Acceptance uses only registered flags, so no input reaches an output.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign aft = thr_sel(int'(afull_thr), AF_DEFAULT);
  assign aet = thr_sel(int'(aempty_thr), AE_DEFAULT);

  // Occupancy after this edge; flags are derived from it so they move with count.
  always_comb begin
    next_count = count;
    if (push_ok && !pop_ok)      next_count = count + ONE_C;
    else if (pop_ok && !push_ok) next_count = count - ONE_C;
  end

  // Pointers, count, flags, strobes and error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      valid_out    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count        <= next_count;
      full         <= (next_count == DEPTH_C);
      empty        <= (next_count == '0);
      almost_full  <= (int'(next_count) >= aft);
      almost_empty <= (int'(next_count) <= aet);
      valid_out    <= pop_ok;
      overflow     <= push & full;
      underflow    <= pop & empty;
    end
  end

  // The RAM read register has no reset; mask it until the first read after reset.
  always_ff @(posedge clk) begin
    if (!reset)      out_clr <= 1'b1;
    else if (pop_ok) out_clr <= 1'b0;
  end

  assign data_out = out_clr ? '0 : ram_rdata;

  param_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (push_ok & reset),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (pop_ok & reset),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_param_fifo.sv
// Directed plan plus randomized traffic against a queue-based reference model.
module tb_param_fifo;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW:0]   afull_thr = '0, aempty_thr = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0, m_ov = 1'b0, m_un = 1'b0;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .data_out(data_out), .valid_out(valid_out), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all();
    int n, aft, aet;
    n   = q.size();
    aft = (afull_thr == 0) ? DEPTH - 2 : int'(afull_thr);
    aet = (aempty_thr == 0) ? 1 : int'(aempty_thr);
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= aft));
    chk("almost_empty", 32'(almost_empty), 32'(n <= aet));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("valid_out",    32'(valid_out),    32'(m_valid));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic step(input logic p, input logic r, input logic [DW-1:0] d, input logic rst_n);
    bit was_full, was_empty;
    push = p; pop = r; data_in = d; reset = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ov    = p && was_full;
      m_un    = r && was_empty;
      m_valid = r && !was_empty;
      if (m_valid) m_dout = q.pop_front();
      if (p && !was_full) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);

    // Fill 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, DW'(i), 1);
      if (i == 2) chk("ae_off_after2", 32'(almost_empty), 0);
      if (i == 6) chk("af_on_after6", 32'(almost_full), 1);
    end
    chk("full_after8", 32'(full), 1);

    // Overflow
    step(1, 0, 10'h3FF, 1);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    step(0, 0, '0, 1);
    chk("ovf_single", 32'(overflow), 0);

    // Drain with ordered data
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 1, '0, 1);
      chk("drain_data", 32'(data_out), 32'(i));
    end
    chk("empty_after_drain", 32'(empty), 1);
    step(0, 1, '0, 1);
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_valid", 32'(valid_out), 0);

    // Steady state at count 4 with simultaneous push/pop
    for (int i = 0; i < 4; i++) step(1, 0, DW'(10'h100 + i), 1);
    for (int i = 4; i < 24; i++) step(1, 1, DW'(10'h100 + i), 1);
    chk("steady_count", 32'(count), 4);
    chk("steady_data", 32'(data_out), 32'h100 + 19);
    while (q.size() > 0) step(0, 1, '0, 1);
    step(1, 1, 10'h155, 1);
    chk("pp_empty_udf", 32'(underflow), 1);
    chk("pp_empty_count", 32'(count), 1);
    step(0, 1, '0, 1);

    // Programmed thresholds
    afull_thr = 4'd3; aempty_thr = 4'd2;
    for (int i = 0; i < 3; i++) step(1, 0, DW'(10'h50 + i), 1);
    chk("thr_af3", 32'(almost_full), 1);
    chk("thr_ae3", 32'(almost_empty), 0);
    step(0, 1, '0, 1);
    chk("thr_af2", 32'(almost_full), 0);
    chk("thr_ae2", 32'(almost_empty), 1);
    afull_thr = '0; aempty_thr = '0;

    // Reset mid-stream at count 5
    while (q.size() < 5) step(1, 0, DW'($urandom), 1);
    step(1, 1, 10'h123, 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_dout", 32'(data_out), 0);
    step(1, 0, 10'h2AA, 1);
    step(0, 1, '0, 1);
    chk("post_rst_data", 32'(data_out), 32'h2AA);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        afull_thr  = AW'(0) + ($urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 10)));
        aempty_thr = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 10));
      end
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           DW'($urandom), 1'($urandom_range(0, 199) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
